analog_seq_ctrl: RTL and testbench

- Top-level sequencer for one analog Ising run.
- On a start pulse it:
  - loads the WWL timing and transfer-count configuration into the analog configuration block;
  - kicks the J/h data transfer and waits for it to finish;
  - runs settle and anneal windows on the macro;
  - samples the spin vector and hands it downstream over a valid/ready port.
- Repeats settle/anneal/sample for a programmed number of iterations without reloading J/h.
- Sits between the host register file and the analog configuration block and macro.

---
 rtl/analog_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_analog_seq_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/analog_seq_ctrl.sv
// analog_seq_ctrl
//   Top-level sequencer for one analog Ising run. A start pulse loads the
//   WWL timing / transfer-count configuration, optionally kicks the J/h data
//   transfer and waits for it, then runs settle / anneal / sample for the
//   programmed number of iterations, handing each spin vector downstream over
//   a valid/ready port. J/h are loaded once per run, never per iteration.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   en_i, start_i, abort_i       enable (low = abort), start pulse, abort
//   skip_cfg_i                   skip the J/h transfer (sampled in LOAD)
//   cycle_per_wwl_high/low_i,    forwarded configuration, shadowed onto the
//   cfg_trans_num_i              matching _o ports in LOAD
//   settle/anneal_cycles_i,      window lengths and iteration count
//   num_iter_i                   (sampled in LOAD, 0 anneal/iter means 1)
//   cfg_configure_enable_o       load strobe to the configuration block
//   dt_cfg_enable_o, dt_cfg_idle_i  data-transfer kick and idle status
//   anneal_en_o, spin_ren_o      macro anneal enable, spin sample strobe
//   spin_rdata_i                 macro spin read data
//   spin_o, spin_valid_o,        captured spin vector and its handshake
//   spin_ready_i
//   iter_o                       current iteration index
//   busy_o, done_o, aborted_o    status, completion pulse, abort pulse
module analog_seq_ctrl #(
  parameter int unsigned NUM_SPIN         = 256,
  parameter int unsigned COUNTER_BITWIDTH = 16,
  parameter int unsigned ITER_BITWIDTH    = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic                        skip_cfg_i,
  input  logic [COUNTER_BITWIDTH-1:0] cycle_per_wwl_high_i,
  input  logic [COUNTER_BITWIDTH-1:0] cycle_per_wwl_low_i,
  input  logic [COUNTER_BITWIDTH-1:0] cfg_trans_num_i,
  input  logic [COUNTER_BITWIDTH-1:0] settle_cycles_i,
  input  logic [COUNTER_BITWIDTH-1:0] anneal_cycles_i,
  input  logic [ITER_BITWIDTH-1:0]    num_iter_i,
  output logic                        cfg_configure_enable_o,
  output logic [COUNTER_BITWIDTH-1:0] cycle_per_wwl_high_o,
  output logic [COUNTER_BITWIDTH-1:0] cycle_per_wwl_low_o,
  output logic [COUNTER_BITWIDTH-1:0] cfg_trans_num_o,
  output logic                        dt_cfg_enable_o,
  input  logic                        dt_cfg_idle_i,
  output logic                        anneal_en_o,
  output logic                        spin_ren_o,
  input  logic [NUM_SPIN-1:0]         spin_rdata_i,
  output logic [NUM_SPIN-1:0]         spin_o,
  output logic                        spin_valid_o,
  input  logic                        spin_ready_i,
  output logic [ITER_BITWIDTH-1:0]    iter_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        aborted_o
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD   = 4'd1,
    ST_KICK   = 4'd2,
    ST_CWAIT  = 4'd3,
    ST_SETTLE = 4'd4,
    ST_ANNEAL = 4'd5,
    ST_SAMPLE = 4'd6,
    ST_OUT    = 4'd7,
    ST_DONE   = 4'd8
  } state_e;

  localparam logic [COUNTER_BITWIDTH-1:0] CNT_ONE  = COUNTER_BITWIDTH'(1);
  localparam logic [ITER_BITWIDTH-1:0]    ITER_ONE = ITER_BITWIDTH'(1);

  state_e                      state_q, state_d;
  logic [COUNTER_BITWIDTH-1:0] cnt_q, cnt_d;
  logic [COUNTER_BITWIDTH-1:0] wwl_high_q, wwl_high_d;
  logic [COUNTER_BITWIDTH-1:0] wwl_low_q, wwl_low_d;
  logic [COUNTER_BITWIDTH-1:0] trans_num_q, trans_num_d;
  logic [COUNTER_BITWIDTH-1:0] settle_q, settle_d;
  logic [COUNTER_BITWIDTH-1:0] anneal_q, anneal_d;
  logic [ITER_BITWIDTH-1:0]    num_iter_q, num_iter_d;
  logic [ITER_BITWIDTH-1:0]    iter_q, iter_d;
  logic [NUM_SPIN-1:0]         spin_q, spin_d;
  logic                        cwait_armed_q, cwait_armed_d;
  logic                        aborted_q, aborted_d;

  logic                        stop;
  logic [COUNTER_BITWIDTH-1:0] anneal_in_norm;
  logic [ITER_BITWIDTH-1:0]    num_iter_in_norm;
  logic [COUNTER_BITWIDTH-1:0] settle_eff;
  logic [COUNTER_BITWIDTH-1:0] anneal_eff;
  state_e                      win_state;
  logic [COUNTER_BITWIDTH-1:0] win_cnt;

  assign stop             = (abort_i | ~en_i) & (state_q != ST_IDLE);
  assign anneal_in_norm   = (anneal_cycles_i == '0) ? CNT_ONE : anneal_cycles_i;
  assign num_iter_in_norm = (num_iter_i == '0) ? ITER_ONE : num_iter_i;

  // Entry into the settle/anneal window. Out of LOAD the latched copies are
  // not yet visible, so the live inputs are used; a zero settle length skips
  // SETTLE and loads the anneal length straight away.
  always_comb begin
    settle_eff = (state_q == ST_LOAD) ? settle_cycles_i : settle_q;
    anneal_eff = (state_q == ST_LOAD) ? anneal_in_norm : anneal_q;
    if (settle_eff != '0) begin
      win_state = ST_SETTLE;
      win_cnt   = settle_eff;
    end else begin
      win_state = ST_ANNEAL;
      win_cnt   = anneal_eff;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wwl_high_d    = wwl_high_q;
    wwl_low_d     = wwl_low_q;
    trans_num_d   = trans_num_q;
    settle_d      = settle_q;
    anneal_d      = anneal_q;
    num_iter_d    = num_iter_q;
    iter_d        = iter_q;
    spin_d        = spin_q;
    cwait_armed_d = cwait_armed_q;
    aborted_d     = 1'b0;

    if (stop) begin
      // Abort wins over every other transition; nothing is latched or
      // captured in the aborting cycle.
      state_d   = ST_IDLE;
      cnt_d     = '0;
      aborted_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i && en_i && !abort_i) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          wwl_high_d  = cycle_per_wwl_high_i;
          wwl_low_d   = cycle_per_wwl_low_i;
          trans_num_d = cfg_trans_num_i;
          settle_d    = settle_cycles_i;
          anneal_d    = anneal_in_norm;
          num_iter_d  = num_iter_in_norm;
          iter_d      = '0;
          // skip_cfg only steers this one decision, so it is consumed here
          // rather than held in a register.
          if (skip_cfg_i) begin
            state_d = win_state;
            cnt_d   = win_cnt;
          end else begin
            state_d = ST_KICK;
          end
        end
        ST_KICK: begin
          cwait_armed_d = 1'b0;
          state_d       = ST_CWAIT;
        end
        ST_CWAIT: begin
          // The transfer block's busy flag lags the kick by one cycle, so
          // its idle status is only trusted from the second CWAIT cycle.
          cwait_armed_d = 1'b1;
          if (cwait_armed_q && dt_cfg_idle_i) begin
            state_d = win_state;
            cnt_d   = win_cnt;
          end
        end
        ST_SETTLE: begin
          if (cnt_q <= CNT_ONE) begin
            state_d = ST_ANNEAL;
            cnt_d   = anneal_q;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_ANNEAL: begin
          if (cnt_q <= CNT_ONE) begin
            state_d = ST_SAMPLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_SAMPLE: begin
          spin_d  = spin_rdata_i;
          state_d = ST_OUT;
        end
        ST_OUT: begin
          if (spin_ready_i) begin
            if (iter_q == (num_iter_q - ITER_ONE)) begin
              state_d = ST_DONE;
            end else begin
              iter_d  = iter_q + ITER_ONE;
              state_d = win_state;
              cnt_d   = win_cnt;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      wwl_high_q    <= '0;
      wwl_low_q     <= '0;
      trans_num_q   <= '0;
      settle_q      <= '0;
      anneal_q      <= '0;
      num_iter_q    <= '0;
      iter_q        <= '0;
      spin_q        <= '0;
      cwait_armed_q <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wwl_high_q    <= wwl_high_d;
      wwl_low_q     <= wwl_low_d;
      trans_num_q   <= trans_num_d;
      settle_q      <= settle_d;
      anneal_q      <= anneal_d;
      num_iter_q    <= num_iter_d;
      iter_q        <= iter_d;
      spin_q        <= spin_d;
      cwait_armed_q <= cwait_armed_d;
      aborted_q     <= aborted_d;
    end
  end

  assign cfg_configure_enable_o = (state_q == ST_LOAD);
  assign dt_cfg_enable_o        = (state_q == ST_KICK);
  assign anneal_en_o            = (state_q == ST_ANNEAL);
  assign spin_ren_o             = (state_q == ST_SAMPLE);
  assign spin_valid_o           = (state_q == ST_OUT);
  assign done_o                 = (state_q == ST_DONE);
  assign busy_o                 = (state_q != ST_IDLE);
  assign aborted_o              = aborted_q;
  assign cycle_per_wwl_high_o   = wwl_high_q;
  assign cycle_per_wwl_low_o    = wwl_low_q;
  assign cfg_trans_num_o        = trans_num_q;
  assign spin_o                 = spin_q;
  assign iter_o                 = iter_q;

endmodule

// File: tb/tb_analog_seq_ctrl.sv
// tb_analog_seq_ctrl
//   The whole stimulus timeline and the expected output timeline are built up
//   front from run descriptions (phase lengths derived from the configured
//   window lengths, iteration counts and handshake waits), then replayed one
//   cycle at a time while a compare process checks every output.
module tb_analog_seq_ctrl;

  localparam int unsigned NS = 256;
  localparam int unsigned CW = 16;
  localparam int unsigned IW = 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1, en_i = 1'b0, start_i = 1'b0, abort_i = 1'b0;
  logic          skip_cfg_i = 1'b0, dt_cfg_idle_i = 1'b1, spin_ready_i = 1'b0;
  logic [CW-1:0] cycle_per_wwl_high_i = '0, cycle_per_wwl_low_i = '0;
  logic [CW-1:0] cfg_trans_num_i = '0, settle_cycles_i = '0, anneal_cycles_i = '0;
  logic [IW-1:0] num_iter_i = '0;
  logic [NS-1:0] spin_rdata_i = '0;
  logic          cfg_configure_enable_o, dt_cfg_enable_o, anneal_en_o, spin_ren_o;
  logic          spin_valid_o, busy_o, done_o, aborted_o;
  logic [CW-1:0] cycle_per_wwl_high_o, cycle_per_wwl_low_o, cfg_trans_num_o;
  logic [NS-1:0] spin_o;
  logic [IW-1:0] iter_o;

  always #5 clk = ~clk;

  analog_seq_ctrl #(.NUM_SPIN(NS), .COUNTER_BITWIDTH(CW), .ITER_BITWIDTH(IW)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .start_i(start_i), .abort_i(abort_i),
    .skip_cfg_i(skip_cfg_i),
    .cycle_per_wwl_high_i(cycle_per_wwl_high_i), .cycle_per_wwl_low_i(cycle_per_wwl_low_i),
    .cfg_trans_num_i(cfg_trans_num_i), .settle_cycles_i(settle_cycles_i),
    .anneal_cycles_i(anneal_cycles_i), .num_iter_i(num_iter_i),
    .cfg_configure_enable_o(cfg_configure_enable_o),
    .cycle_per_wwl_high_o(cycle_per_wwl_high_o), .cycle_per_wwl_low_o(cycle_per_wwl_low_o),
    .cfg_trans_num_o(cfg_trans_num_o), .dt_cfg_enable_o(dt_cfg_enable_o),
    .dt_cfg_idle_i(dt_cfg_idle_i), .anneal_en_o(anneal_en_o), .spin_ren_o(spin_ren_o),
    .spin_rdata_i(spin_rdata_i), .spin_o(spin_o), .spin_valid_o(spin_valid_o),
    .spin_ready_i(spin_ready_i), .iter_o(iter_o), .busy_o(busy_o), .done_o(done_o),
    .aborted_o(aborted_o)
  );

  typedef struct {
    logic rst, en, start, abort, skip;
    logic [CW-1:0] hi, lo, trans, settle, anneal;
    logic [IW-1:0] niter;
    logic idle, ready;
    logic [NS-1:0] rdata;
  } stim_t;

  typedef struct {
    bit chk;
    logic cfg_en, dt_en, anneal_en, ren, valid, busy, done, aborted;
    logic [CW-1:0] hi, lo, trans;
    logic [IW-1:0] iter;
    logic [NS-1:0] spin;
  } exp_t;

  typedef enum {PH_IDLE, PH_LOAD, PH_KICK, PH_CWAIT, PH_SETTLE, PH_ANNEAL,
                PH_SAMPLE, PH_OUT, PH_DONE} ph_e;

  typedef struct { ph_e ph; int idle; int ready; } plan_t;

  typedef struct {
    logic [CW-1:0] hi, lo, trans, settle, anneal;
    logic [IW-1:0] niter;
    logic skip;
    int dlen, idle1, wait_fix, term_kind, term_at, start_busy;
  } run_t;

  typedef struct { int cyc; int sig; int val; } pin_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  pin_t  pins[$];

  logic [CW-1:0] m_hi, m_lo, m_tr;
  logic [NS-1:0] m_spin;
  logic [IW-1:0] m_iter;

  int cyc = -1;
  int n_pass = 0;
  int n_total = 0;

  function automatic logic [NS-1:0] rspin();
    logic [NS-1:0] v;
    for (int k = 0; k < int'(NS / 32); k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst = 1'b0; s.en = 1'b1; s.start = 1'b0; s.abort = 1'b0;
    s.skip = 1'($urandom);
    s.hi = CW'($urandom); s.lo = CW'($urandom); s.trans = CW'($urandom);
    s.settle = CW'($urandom); s.anneal = CW'($urandom); s.niter = IW'($urandom);
    s.idle = 1'($urandom); s.ready = 1'($urandom);
    s.rdata = rspin();
    return s;
  endfunction

  function automatic plan_t mk(ph_e ph, int idle, int ready);
    plan_t p;
    p.ph = ph; p.idle = idle; p.ready = ready;
    return p;
  endfunction

  function automatic exp_t phase_exp(ph_e ph);
    exp_t e;
    e.chk = 1'b1;
    e.cfg_en = (ph == PH_LOAD);   e.dt_en = (ph == PH_KICK);
    e.anneal_en = (ph == PH_ANNEAL); e.ren = (ph == PH_SAMPLE);
    e.valid = (ph == PH_OUT);     e.done = (ph == PH_DONE);
    e.busy = (ph != PH_IDLE);     e.aborted = 1'b0;
    e.hi = m_hi; e.lo = m_lo; e.trans = m_tr; e.iter = m_iter; e.spin = m_spin;
    return e;
  endfunction

  task automatic model_zero();
    m_hi = '0; m_lo = '0; m_tr = '0; m_spin = '0; m_iter = '0;
  endtask

  // One idle cycle; start is only raised when en/abort must block it.
  task automatic emit_idle(input logic ab);
    stim_t s; exp_t e;
    s = rand_stim();
    s.en = ($urandom_range(0, 3) != 0);
    s.abort = ($urandom_range(0, 3) == 0);
    s.start = (!s.en || s.abort) ? 1'($urandom) : 1'b0;
    e = phase_exp(PH_IDLE);
    e.aborted = ab;
    stim_q.push_back(s); exp_q.push_back(e);
  endtask

  function automatic run_t rand_run();
    run_t r;
    r.hi = CW'($urandom); r.lo = CW'($urandom); r.trans = CW'($urandom);
    r.settle = CW'($urandom_range(0, 5)); r.anneal = CW'($urandom_range(0, 6));
    r.niter = IW'($urandom_range(0, 4)); r.skip = 1'($urandom);
    r.dlen = $urandom_range(2, 6); r.idle1 = $urandom_range(0, 1);
    r.wait_fix = -1;
    r.term_kind = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    r.term_at = -1;
    r.start_busy = $urandom_range(0, 1);
    return r;
  endfunction

  // term_kind: 1 abort_i, 2 en_i low, 3 rst_i, raised in run cycle term_at.
  task automatic build_run(input run_t r, output int base);
    plan_t plan[$];
    int iters, ann, w, tat;
    bit stopped;
    stim_t s; exp_t e;
    iters = (r.niter == 0) ? 1 : int'(r.niter);
    ann   = (r.anneal == 0) ? 1 : int'(r.anneal);
    base  = stim_q.size();
    plan.push_back(mk(PH_IDLE, -1, -1));
    plan.push_back(mk(PH_LOAD, -1, -1));
    if (!r.skip) begin
      plan.push_back(mk(PH_KICK, -1, -1));
      for (int c = 1; c <= r.dlen; c++)
        plan.push_back(mk(PH_CWAIT, (c == 1) ? r.idle1 : ((c == r.dlen) ? 1 : 0), -1));
    end
    for (int it = 0; it < iters; it++) begin
      for (int k = 0; k < int'(r.settle); k++) plan.push_back(mk(PH_SETTLE, -1, -1));
      for (int k = 0; k < ann; k++) plan.push_back(mk(PH_ANNEAL, -1, -1));
      plan.push_back(mk(PH_SAMPLE, -1, -1));
      w = (r.wait_fix >= 0) ? r.wait_fix : $urandom_range(0, 4);
      for (int k = 0; k <= w; k++) plan.push_back(mk(PH_OUT, -1, (k == w) ? 1 : 0));
    end
    plan.push_back(mk(PH_DONE, -1, -1));
    tat = r.term_at;
    if (r.term_kind != 0 && tat < 0) tat = $urandom_range(1, plan.size() - 1);
    stopped = 1'b0;
    for (int i = 0; i < plan.size(); i++) begin
      s = rand_stim();
      s.skip = r.skip; s.hi = r.hi; s.lo = r.lo; s.trans = r.trans;
      s.settle = r.settle; s.anneal = r.anneal; s.niter = r.niter;
      s.start = (i == 0) ? 1'b1 : ((r.start_busy != 0) ? 1'b1 : 1'($urandom));
      if (plan[i].idle >= 0) s.idle = plan[i].idle[0];
      if (plan[i].ready >= 0) s.ready = plan[i].ready[0];
      e = phase_exp(plan[i].ph);
      if (r.term_kind != 0 && i == tat) begin
        if (r.term_kind == 1) s.abort = 1'b1;
        else if (r.term_kind == 2) s.en = 1'b0;
        else s.rst = 1'b1;
        stim_q.push_back(s); exp_q.push_back(e);
        stopped = 1'b1;
        break;
      end
      stim_q.push_back(s); exp_q.push_back(e);
      case (plan[i].ph)
        PH_LOAD: begin m_hi = r.hi; m_lo = r.lo; m_tr = r.trans; m_iter = '0; end
        PH_SAMPLE: m_spin = s.rdata;
        PH_OUT: if (s.ready && int'(m_iter) != iters - 1) m_iter = m_iter + IW'(1);
        default: ;
      endcase
    end
    if (stopped) begin
      if (r.term_kind == 3) begin
        model_zero();
        emit_idle(1'b0);
      end else begin
        emit_idle(1'b1);
      end
    end
    for (int g = 0; g < 2 + $urandom_range(0, 1); g++) emit_idle(1'b0);
  endtask

  task automatic pin(input int c, input int sig, input int val);
    pin_t p;
    p.cyc = c; p.sig = sig; p.val = val;
    pins.push_back(p);
  endtask

  task automatic build_all();
    stim_t s; exp_t e; run_t r; int b;
    s = rand_stim(); s.rst = 1'b1; s.en = 1'b0;
    e = phase_exp(PH_IDLE); e.chk = 1'b0;
    stim_q.push_back(s); exp_q.push_back(e);
    model_zero();
    s = rand_stim(); s.rst = 1'b1; s.en = 1'b0;
    e = phase_exp(PH_IDLE);
    stim_q.push_back(s); exp_q.push_back(e);
    emit_idle(1'b0); emit_idle(1'b0);

    // full run, idle returns 20 cycles after the kick
    r = rand_run();
    r.hi = 16'd3; r.lo = 16'd2; r.trans = 16'd4; r.settle = 16'd5; r.anneal = 16'd10;
    r.niter = 8'd1; r.skip = 1'b0; r.dlen = 20; r.idle1 = 1; r.wait_fix = 0;
    r.term_kind = 0;
    build_run(r, b);
    pin(b+1, 0, 1); pin(b+2, 1, 1); pin(b+27, 2, 0); pin(b+28, 2, 1);
    pin(b+37, 2, 1); pin(b+38, 2, 0); pin(b+38, 3, 1); pin(b+39, 4, 1);
    pin(b+40, 5, 1); pin(b+41, 6, 0);

    // skip transfer, settle 0, anneal 0
    r = rand_run();
    r.skip = 1'b1; r.settle = '0; r.anneal = '0; r.niter = 8'd1; r.term_kind = 0;
    build_run(r, b);
    pin(b+2, 1, 0); pin(b+2, 2, 1); pin(b+3, 2, 0); pin(b+3, 3, 1);

    // three iterations, ready held off 4 cycles each
    r = rand_run();
    r.skip = 1'b1; r.settle = '0; r.anneal = 16'd1; r.niter = 8'd3; r.wait_fix = 4;
    r.term_kind = 0;
    build_run(r, b);
    pin(b+4, 8, 0); pin(b+11, 8, 1); pin(b+18, 8, 2);
    pin(b+8, 4, 1); pin(b+9, 4, 0); pin(b+23, 5, 1);

    // idle ignored in first CWAIT cycle, low in second, high in third
    r = rand_run();
    r.skip = 1'b0; r.dlen = 3; r.idle1 = 1; r.settle = '0; r.anneal = 16'd3;
    r.niter = 8'd1; r.term_kind = 0;
    build_run(r, b);
    pin(b+5, 2, 0); pin(b+6, 2, 1);

    // abort in the 4th anneal cycle, start held high while busy
    r = rand_run();
    r.skip = 1'b0; r.dlen = 2; r.idle1 = 1; r.settle = 16'd2; r.anneal = 16'd8;
    r.niter = 8'd1; r.term_kind = 1; r.term_at = 10; r.start_busy = 1;
    build_run(r, b);
    pin(b+10, 2, 1); pin(b+11, 2, 0); pin(b+11, 7, 1); pin(b+11, 6, 0);
    pin(b+11, 5, 0); pin(b+12, 7, 0);

    // reset during OUT, then a normal run
    r = rand_run();
    r.skip = 1'b1; r.settle = 16'd1; r.anneal = 16'd1; r.niter = 8'd1; r.wait_fix = 3;
    r.term_kind = 3; r.term_at = 6;
    build_run(r, b);
    pin(b+6, 4, 1); pin(b+7, 4, 0); pin(b+7, 6, 0);
    r = rand_run(); r.term_kind = 0;
    build_run(r, b);

    for (int n = 0; n < 24; n++) begin
      r = rand_run();
      build_run(r, b);
    end
  endtask

  task automatic chk(input string name, input logic [NS-1:0] act, input logic [NS-1:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
  endtask

  exp_t e_cur;
  logic [NS-1:0] pin_act;

  always @(negedge clk) begin
    if (cyc >= 0) begin
      e_cur = exp_q[cyc];
      if (e_cur.chk) begin
        chk("cfg_configure_enable_o", NS'(cfg_configure_enable_o), NS'(e_cur.cfg_en));
        chk("cycle_per_wwl_high_o", NS'(cycle_per_wwl_high_o), NS'(e_cur.hi));
        chk("cycle_per_wwl_low_o", NS'(cycle_per_wwl_low_o), NS'(e_cur.lo));
        chk("cfg_trans_num_o", NS'(cfg_trans_num_o), NS'(e_cur.trans));
        chk("dt_cfg_enable_o", NS'(dt_cfg_enable_o), NS'(e_cur.dt_en));
        chk("anneal_en_o", NS'(anneal_en_o), NS'(e_cur.anneal_en));
        chk("spin_ren_o", NS'(spin_ren_o), NS'(e_cur.ren));
        chk("spin_o", spin_o, e_cur.spin);
        chk("spin_valid_o", NS'(spin_valid_o), NS'(e_cur.valid));
        chk("iter_o", NS'(iter_o), NS'(e_cur.iter));
        chk("busy_o", NS'(busy_o), NS'(e_cur.busy));
        chk("done_o", NS'(done_o), NS'(e_cur.done));
        chk("aborted_o", NS'(aborted_o), NS'(e_cur.aborted));
      end
      foreach (pins[k]) begin
        if (pins[k].cyc == cyc) begin
          case (pins[k].sig)
            0: pin_act = NS'(cfg_configure_enable_o);
            1: pin_act = NS'(dt_cfg_enable_o);
            2: pin_act = NS'(anneal_en_o);
            3: pin_act = NS'(spin_ren_o);
            4: pin_act = NS'(spin_valid_o);
            5: pin_act = NS'(done_o);
            6: pin_act = NS'(busy_o);
            7: pin_act = NS'(aborted_o);
            default: pin_act = NS'(iter_o);
          endcase
          chk($sformatf("pin_sig%0d", pins[k].sig), pin_act, NS'(pins[k].val));
        end
      end
    end
  end

  task automatic apply(input stim_t s);
    rst_i = s.rst; en_i = s.en; start_i = s.start; abort_i = s.abort;
    skip_cfg_i = s.skip;
    cycle_per_wwl_high_i = s.hi; cycle_per_wwl_low_i = s.lo; cfg_trans_num_i = s.trans;
    settle_cycles_i = s.settle; anneal_cycles_i = s.anneal; num_iter_i = s.niter;
    dt_cfg_idle_i = s.idle; spin_ready_i = s.ready; spin_rdata_i = s.rdata;
  endtask

  initial begin
    build_all();
    for (int i = 0; i < stim_q.size(); i++) begin
      @(posedge clk);
      #1;
      apply(stim_q[i]);
      cyc = i;
    end
    @(posedge clk);
    #1;
    cyc = -1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
